// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder: synchronizes the phases, turns each legal Gray-code step into +1/-1 on a wrapping counter.
// Latency: SYNC_STAGES cycles from the first sampling edge to count/dir/step.
// Backpressure: none; cnt_en freezes the counter while decode and error detection keep running.
module quad_decoder_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             cnt_en,
    input  logic             clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam logic [2:0]       WARM_CYCLES = 3'(SYNC_STAGES + 1);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [1:0]             cur;
    logic [1:0]             prev;
    logic [1:0]             up_next;
    logic [2:0]             warm_cnt;
    logic                   live;
    logic                   is_up;
    logic                   is_down;
    logic                   is_bad;

    assign cur = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    // Successor of prev in the A-leads-B order 00->10->11->01->00.
    always_comb begin
        up_next = 2'b00;
        case (prev)
            2'b00:   up_next = 2'b10;
            2'b10:   up_next = 2'b11;
            2'b11:   up_next = 2'b01;
            default: up_next = 2'b00;
        endcase
    end

    // The synchronizer fill after reset can look like a double-bit jump, hence the warm-up gate.
    assign live    = (warm_cnt == WARM_CYCLES);
    assign is_bad  = live && (cur == ~prev);
    assign is_up   = live && (cur == up_next);
    assign is_down = live && (cur != prev) && !is_up && !is_bad;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_sync   <= '0;
            b_sync   <= '0;
            prev     <= 2'b00;
            warm_cnt <= 3'd0;
            count    <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            err      <= 1'b0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], quad_a};
            b_sync <= {b_sync[SYNC_STAGES-2:0], quad_b};
            prev   <= cur;
            if (!live) begin
                warm_cnt <= warm_cnt + 3'd1;
            end

            step <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (cnt_en && (is_up || is_down)) begin
                count <= is_up ? count + ONE : count - ONE;
                dir   <= is_up;
                step  <= 1'b1;
            end

            // A fresh illegal jump outranks a clear request in the same cycle.
            if (is_bad) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed bench for quad_decoder_counter: vector table plus hand-timed corner sequences.
module tb_quad_decoder_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       quad_a = 1'b0;
    logic       quad_b = 1'b0;
    logic       cnt_en = 1'b1;
    logic       clr = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] count;
    logic       dir;
    logic       step;
    logic       err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] ab;
        logic       en;
        logic       clr;
        logic       eclr;
        int         cnt;
        logic       dir;
        int         steps;
        logic       err;
    } vec_t;

    vec_t vq[$];

    quad_decoder_counter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .quad_a  (quad_a),
        .quad_b  (quad_b),
        .cnt_en  (cnt_en),
        .clr     (clr),
        .err_clr (err_clr),
        .count   (count),
        .dir     (dir),
        .step    (step),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [1:0] ab, input logic en, input logic c, input logic ec,
                                input int cnt, input logic d, input int steps, input logic e);
        vec_t v;
        v.ab = ab; v.en = en; v.clr = c; v.eclr = ec;
        v.cnt = cnt; v.dir = d; v.steps = steps; v.err = e;
        return v;
    endfunction

    function automatic logic [1:0] up_of(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    initial begin
        int         pulses;
        int         model;
        logic [1:0] pos;

        // Reset with both phases high, then release and hold still.
        quad_a = 1'b1; quad_b = 1'b1;
        @(negedge clk);
        repeat (3) cyc();
        chk("reset_count", count, 0);
        chk("reset_dir", dir, 0);
        chk("reset_step", step, 0);
        chk("reset_err", err, 0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("warm11_stepcnterr", {count, step, err}, 0);
        end

        // Re-home at 00 through another reset.
        rst = 1'b0; quad_a = 1'b0; quad_b = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        repeat (6) cyc();

        // ab, en, clr, eclr -> count, dir, steps in window, err
        for (int i = 0; i < 16; i++) begin
            vq.push_back(mk(up_of(2'(i)) == 2'b00 ? 2'b00 : 2'b00, 1, 0, 0, 0, 0, 0, 0));
            vq.pop_back();
        end
        pos = 2'b00;
        for (int i = 1; i <= 16; i++) begin
            pos = up_of(pos);
            vq.push_back(mk(pos, 1, 0, 0, i, 1, 1, 0));
        end
        vq.push_back(mk(2'b00, 1, 1, 0, 0,   1, 0, 0));
        vq.push_back(mk(2'b01, 1, 0, 0, 255, 0, 1, 0));
        vq.push_back(mk(2'b11, 1, 0, 0, 254, 0, 1, 0));
        vq.push_back(mk(2'b10, 1, 0, 0, 253, 0, 1, 0));
        vq.push_back(mk(2'b00, 1, 0, 0, 252, 0, 1, 0));
        vq.push_back(mk(2'b11, 1, 0, 0, 252, 0, 0, 1));
        vq.push_back(mk(2'b01, 1, 0, 0, 253, 1, 1, 1));
        vq.push_back(mk(2'b01, 1, 0, 1, 253, 1, 0, 0));

        foreach (vq[i]) begin
            {quad_a, quad_b} = vq[i].ab;
            cnt_en = vq[i].en; clr = vq[i].clr; err_clr = vq[i].eclr;
            pulses = 0;
            for (int c = 0; c < 4; c++) begin
                cyc();
                if (step) pulses++;
            end
            chk($sformatf("vec%0d_count", i), count, vq[i].cnt);
            chk($sformatf("vec%0d_dir", i), dir, vq[i].dir);
            chk($sformatf("vec%0d_steps", i), pulses, vq[i].steps);
            chk($sformatf("vec%0d_err", i), err, vq[i].err);
        end
        clr = 1'b0; err_clr = 1'b0; cnt_en = 1'b1;

        // err_clr lands on the very edge a new illegal jump (01->10) decodes.
        {quad_a, quad_b} = 2'b10;
        cyc();
        cyc();
        chk("coinc_err_before", err, 0);
        err_clr = 1'b1;
        cyc();
        chk("coinc_err_wins", err, 1);
        chk("coinc_count", count, 253);
        err_clr = 1'b0;
        cyc();

        vq.delete();
        vq.push_back(mk(2'b10, 1, 1, 0, 0, 1, 0, 1));
        pos = 2'b10;
        for (int i = 1; i <= 5; i++) begin
            pos = up_of(pos);
            vq.push_back(mk(pos, 1, 0, 0, i, 1, 1, 1));
        end
        foreach (vq[i]) begin
            {quad_a, quad_b} = vq[i].ab;
            cnt_en = vq[i].en; clr = vq[i].clr; err_clr = vq[i].eclr;
            pulses = 0;
            for (int c = 0; c < 4; c++) begin
                cyc();
                if (step) pulses++;
            end
            chk($sformatf("clrvec%0d_count", i), count, vq[i].cnt);
            chk($sformatf("clrvec%0d_steps", i), pulses, vq[i].steps);
            chk($sformatf("clrvec%0d_err", i), err, vq[i].err);
        end
        clr = 1'b0;

        // clr coincident with a decoded up step (11->01) at count 5.
        {quad_a, quad_b} = 2'b01;
        cyc();
        cyc();
        chk("clrstep_pre_count", count, 5);
        clr = 1'b1;
        cyc();
        chk("clrstep_count", count, 0);
        chk("clrstep_step", step, 0);
        chk("clrstep_dir", dir, 1);
        clr = 1'b0;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (step) pulses++;
        end
        chk("clrstep_after_steps", pulses, 0);

        // Frozen counter: four up transitions with cnt_en low, then one enabled.
        vq.delete();
        vq.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 1));
        vq.push_back(mk(2'b10, 0, 0, 0, 0, 1, 0, 1));
        vq.push_back(mk(2'b11, 0, 0, 0, 0, 1, 0, 1));
        vq.push_back(mk(2'b01, 0, 0, 0, 0, 1, 0, 1));
        vq.push_back(mk(2'b00, 1, 0, 0, 1, 1, 1, 1));
        foreach (vq[i]) begin
            {quad_a, quad_b} = vq[i].ab;
            cnt_en = vq[i].en; clr = vq[i].clr; err_clr = vq[i].eclr;
            pulses = 0;
            for (int c = 0; c < 4; c++) begin
                cyc();
                if (step) pulses++;
            end
            chk($sformatf("envec%0d_count", i), count, vq[i].cnt);
            chk($sformatf("envec%0d_dir", i), dir, vq[i].dir);
            chk($sformatf("envec%0d_steps", i), pulses, vq[i].steps);
        end

        // Exact latency of one up step 00->10.
        {quad_a, quad_b} = 2'b10;
        cyc();
        chk("lat_edge1", {count, step}, {8'd1, 1'b0});
        cyc();
        chk("lat_edge2", {count, step}, {8'd1, 1'b0});
        cyc();
        chk("lat_edge3", {count, step, dir}, {8'd2, 1'b1, 1'b1});
        cyc();
        chk("lat_edge4_step", step, 0);

        // Clear, then count up to 37 and reset mid-motion.
        clr = 1'b1;
        repeat (2) cyc();
        clr = 1'b0;
        pos = 2'b10;
        model = 0;
        for (int i = 0; i < 37; i++) begin
            pos = up_of(pos);
            {quad_a, quad_b} = pos;
            model = (model + 1) % 256;
            repeat (3) cyc();
        end
        cyc();
        chk("pre_reset_count", count, model);
        chk("pre_reset_count37", count, 37);

        pos = up_of(pos);
        {quad_a, quad_b} = pos;
        rst = 1'b0;
        cyc();
        chk("midrst_count", count, 0);
        chk("midrst_dir", dir, 0);
        chk("midrst_err", err, 0);
        chk("midrst_step", step, 0);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (step || err || count != 8'd0) pulses++;
        end
        chk("midrst_warm_quiet", pulses, 0);
        pos = up_of(pos);
        {quad_a, quad_b} = pos;
        repeat (4) cyc();
        chk("midrst_resume_count", count, 1);
        chk("midrst_resume_dir", dir, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_decoder_counter.md
Name: quad_decoder_counter

Overview:
- Receives the two-phase quadrature signal pair (A/B) from a rotary/linear encoder.
- Synchronizes both inputs and decodes every legal Gray-code transition as one up or one down step.
- Accumulates the steps in a wrapping position counter.
- Sits between the encoder pins and the position/velocity logic. Emits a per-step strobe, a direction flag and a sticky illegal-transition flag.

Parameters:
- WIDTH, 8, width of position counter `count`.
- SYNC_STAGES, 2, flops in each input synchronizer chain. Legal range 2..4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- quad_a  input  1  encoder phase A, asynchronous to clk
- quad_b  input  1  encoder phase B, asynchronous to clk
- cnt_en  input  1  1 = steps modify count/dir/step; 0 = count frozen
- clr  input  1  synchronous clear of count
- err_clr  input  1  synchronous clear of err
- count  output  WIDTH  signed-agnostic position, modulo 2^WIDTH
- dir  output  1  direction of last counted step: 1 = up, 0 = down
- step  output  1  one-cycle pulse per counted step
- err  output  1  sticky: illegal double-bit transition detected

Behaviour:
- Reset (rst=0 at clk edge):
  - count=0, dir=0, step=0, err=0.
  - All synchronizer flops and the previous-state register prev=2'b00.
  - Warm-up counter cleared.
  - rst has priority over every other input.
- Synchronizer:
  - quad_a and quad_b each pass through a SYNC_STAGES flop chain.
  - The final stages form cur={a_s,b_s}.
  - prev<=cur every non-reset cycle, regardless of cnt_en/clr.
- Warm-up:
  - For the first SYNC_STAGES+1 clock edges after rst deasserts, decode is suppressed.
  - During warm-up: no step, no count change, no err; prev still tracks cur.
  - Decode is live from edge SYNC_STAGES+2 onward.
- Decode, comparing cur against prev:
  - Up sequence {A,B}: 00->10->11->01->00 (A leads B).
  - Down sequence: the reverse, 00->01->11->10->00.
  - cur==prev: idle, nothing happens.
  - Single-bit change in the up order: up step.
  - Single-bit change in the down order: down step.
  - Both bits changed: illegal. err<=1; count, dir and step unaffected; prev still updates to cur.
- Step action, when cnt_en=1 and clr=0:
  - Up: count<=count+1, wrapping all-ones -> 0.
  - Down: count<=count-1, wrapping 0 -> all-ones.
  - dir<=1 for up, 0 for down; step<=1 for exactly that cycle.
- cnt_en=0:
  - count, dir hold; step=0.
  - prev tracking and err detection continue.
- clr=1:
  - count<=0 and step=0, overriding any simultaneous step; dir holds.
  - err is unaffected.
- err_clr=1: err<=0, unless an illegal transition is decoded in the same cycle. In that case err stays 1, because a new error wins.
- Latency:
  - An input edge sampled into the first sync stage at edge k is decoded at edge k+SYNC_STAGES.
  - count/step/dir are visible after that edge.
  - With the default parameter: 2 cycles from the first sampling edge.
- Rate limit: each A/B level must be stable for at least 1 clk period after synchronization. Faster input is out of spec and is flagged only if it appears as a double-bit jump.
- Reset mid-operation: the next cycle shows reset values and re-enters warm-up. No step is emitted for the encoder position held across reset.

Test Plan:
- Reset/warm-up:
  - Hold A=1, B=1 through reset release, no further motion.
  - Expect count=0, step=0, err=0 forever; no false error from the 00->11 synchronizer fill.
- Up counting:
  - After warm-up, drive 4 full up cycles (16 transitions, each held ≥4 clk).
  - Expect 16 single-cycle step pulses, dir=1, count=16.
  - Each update lands 2 cycles after its input change.
- Down wrap:
  - From count=0, drive 3 down transitions (00->01->11->10).
  - Expect count=255, then 254, then 253 (WIDTH=8), with dir=0.
- Illegal transition:
  - From 00 jump to 11.
  - Expect err=1, count unchanged, no step.
  - Then one legal up step: count+1, err still 1.
  - Assert err_clr: err=0.
  - Repeat with err_clr coincident with a new illegal jump: err stays 1.
- clr/cnt_en interaction:
  - With count=5, assert clr in the same cycle a step decodes: count=0, step=0.
  - With cnt_en=0, drive 4 up transitions: count holds at 0, step stays 0.
  - Re-enable cnt_en and drive one up step: count=1.
- Reset mid-stream:
  - At count=37 during motion, pulse rst=0 for 1 cycle.
  - Expect count=0, dir=0, err=0 next cycle.
  - No steps during SYNC_STAGES+1 edges; counting resumes correctly afterwards.
